// File: rtl/mult18x18_pp_accum.sv
// Reduces ten radix-4 Booth partial products to a 36-bit product (2 stages)
// and folds it into a 48-bit signed-overflow-checked accumulator (stage 3).
module mult18x18_pp_accum (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ce,
   input  logic        i_valid,
   input  logic        i_multa_ns,
   input  logic        i_multb_ns,
   input  logic        i_acc_load,
   input  logic        i_acc_clr,
   input  logic [19:0] i_pp1,
   input  logic [19:0] i_pp2,
   input  logic [19:0] i_pp3,
   input  logic [19:0] i_pp4,
   input  logic [19:0] i_pp5,
   input  logic [19:0] i_pp6,
   input  logic [19:0] i_pp7,
   input  logic [19:0] i_pp8,
   input  logic [19:0] i_pp9,
   input  logic [19:0] i_pp10,
   output logic [35:0] o_product,
   output logic        o_p_valid,
   output logic [47:0] o_acc,
   output logic        o_acc_valid,
   output logic        o_acc_ovf
);

   function automatic logic [35:0] f_align(input logic [19:0] pp, input logic [4:0] sh);
      logic [35:0] x;
      x = {{16{pp[19]}}, pp};
      return x << sh;
   endfunction

   // Returns {carry, sum}; carry is already shifted to its weight.
   function automatic logic [71:0] f_csa(input logic [35:0] a, input logic [35:0] b,
                                         input logic [35:0] c);
      logic [35:0] cy;
      cy = ((a & b) | (a & c) | (b & c)) << 1;
      return {cy, a ^ b ^ c};
   endfunction

   logic [35:0] w_op [10];
   logic [71:0] w_l1a, w_l1b, w_l1c, w_l2a, w_l2b, w_l3, w_l4, w_l5;
   logic [35:0] w_cpa;
   logic [47:0] w_ext;
   logic [47:0] w_sum;
   logic        w_ovf_add;

   logic [35:0] r_s1_sum;
   logic [35:0] r_s1_carry;
   logic        r_s1_valid;
   logic        r_s1_psigned;
   logic        r_s1_load;
   logic        r_s2_psigned;
   logic        r_s2_load;

   assign w_op[0] = f_align(i_pp1,  5'd0);
   assign w_op[1] = f_align(i_pp2,  5'd2);
   assign w_op[2] = f_align(i_pp3,  5'd4);
   assign w_op[3] = f_align(i_pp4,  5'd6);
   assign w_op[4] = f_align(i_pp5,  5'd8);
   assign w_op[5] = f_align(i_pp6,  5'd10);
   assign w_op[6] = f_align(i_pp7,  5'd12);
   assign w_op[7] = f_align(i_pp8,  5'd14);
   assign w_op[8] = f_align(i_pp9,  5'd16);
   assign w_op[9] = f_align(i_pp10, 5'd18);

   // Wallace-style tree 10 -> 7 -> 5 -> 4 -> 3 -> 2; w_op[9] rides down to the last level.
   assign w_l1a = f_csa(w_op[0], w_op[1], w_op[2]);
   assign w_l1b = f_csa(w_op[3], w_op[4], w_op[5]);
   assign w_l1c = f_csa(w_op[6], w_op[7], w_op[8]);
   assign w_l2a = f_csa(w_l1a[35:0], w_l1a[71:36], w_l1b[35:0]);
   assign w_l2b = f_csa(w_l1b[71:36], w_l1c[35:0], w_l1c[71:36]);
   assign w_l3  = f_csa(w_l2a[35:0], w_l2a[71:36], w_l2b[35:0]);
   assign w_l4  = f_csa(w_l3[35:0], w_l3[71:36], w_l2b[71:36]);
   assign w_l5  = f_csa(w_l4[35:0], w_l4[71:36], w_op[9]);

   assign w_cpa     = r_s1_sum + r_s1_carry;
   assign w_ext     = r_s2_psigned ? {{12{o_product[35]}}, o_product} : {12'd0, o_product};
   assign w_sum     = o_acc + w_ext;
   assign w_ovf_add = (o_acc[47] == w_ext[47]) && (w_sum[47] != o_acc[47]);

   // Stage 1: register the carry-save pair and the control that travels with it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_sum     <= 36'd0;
         r_s1_carry   <= 36'd0;
         r_s1_valid   <= 1'b0;
         r_s1_psigned <= 1'b0;
         r_s1_load    <= 1'b0;
      end else if (i_ce) begin
         r_s1_sum     <= w_l5[35:0];
         r_s1_carry   <= w_l5[71:36];
         r_s1_valid   <= i_valid;
         r_s1_psigned <= i_multa_ns | i_multb_ns;
         r_s1_load    <= i_acc_load;
      end
   end

   // Stage 2: carry-propagate add into the product register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_product    <= 36'd0;
         o_p_valid    <= 1'b0;
         r_s2_psigned <= 1'b0;
         r_s2_load    <= 1'b0;
      end else if (i_ce) begin
         o_product    <= w_cpa;
         o_p_valid    <= r_s1_valid;
         r_s2_psigned <= r_s1_psigned;
         r_s2_load    <= r_s1_load;
      end
   end

   // Stage 3: clear wins over accumulate, but a colliding product is loaded rather than lost.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_acc       <= 48'd0;
         o_acc_valid <= 1'b0;
         o_acc_ovf   <= 1'b0;
      end else if (i_ce) begin
         o_acc_valid <= o_p_valid;
         if (i_acc_clr) begin
            o_acc     <= o_p_valid ? w_ext : 48'd0;
            o_acc_ovf <= 1'b0;
         end else if (o_p_valid) begin
            if (r_s2_load) begin
               o_acc     <= w_ext;
               o_acc_ovf <= 1'b0;
            end else begin
               o_acc     <= w_sum;
               o_acc_ovf <= o_acc_ovf | w_ovf_add;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult18x18_pp_accum.sv
// Self-checking bench: a Booth encoder model drives the partial products,
// a scoreboard checks product and accumulator streams, hand sequences cover corners.
module tb_mult18x18_pp_accum;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        valid;
   logic        multa_ns;
   logic        multb_ns;
   logic        acc_load;
   logic        acc_clr;
   logic [19:0] pp [10];
   logic [35:0] o_product;
   logic        o_p_valid;
   logic [47:0] o_acc;
   logic        o_acc_valid;
   logic        o_acc_ovf;

   typedef struct {
      logic [17:0] a;
      logic [17:0] b;
      logic        sa;
      logic        sb;
      logic [35:0] prod;
      logic [47:0] acc;
   } vec_t;

   typedef struct {
      logic [47:0] acc;
      logic        ovf;
   } acc_t;

   vec_t        tbl [8];
   logic [35:0] q_prod [$];
   acc_t        q_acc [$];
   logic [47:0] m_acc;
   logic        m_ovf;
   bit          sb_en;
   int          n_chk;
   int          n_pass;
   int          run;
   int          max_run;

   mult18x18_pp_accum dut (
      .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid),
      .i_multa_ns(multa_ns), .i_multb_ns(multb_ns),
      .i_acc_load(acc_load), .i_acc_clr(acc_clr),
      .i_pp1(pp[0]), .i_pp2(pp[1]), .i_pp3(pp[2]), .i_pp4(pp[3]), .i_pp5(pp[4]),
      .i_pp6(pp[5]), .i_pp7(pp[6]), .i_pp8(pp[7]), .i_pp9(pp[8]), .i_pp10(pp[9]),
      .o_product(o_product), .o_p_valid(o_p_valid),
      .o_acc(o_acc), .o_acc_valid(o_acc_valid), .o_acc_ovf(o_acc_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass = n_pass + 1;
   endtask

   // Radix-4 Booth encoding: digit k = -2*b[2k+1] + b[2k] + b[2k-1], pp = digit * a.
   function automatic logic [199:0] booth(input logic [17:0] a, input logic [17:0] b,
                                         input logic sa, input logic sb);
      logic signed [63:0] av;
      logic signed [63:0] d;
      logic signed [63:0] p;
      logic [20:0]        bx;
      logic [199:0]       r;
      av = sa ? {{46{a[17]}}, a} : {46'd0, a};
      bx = {sb & b[17], sb & b[17], b, 1'b0};
      r  = 200'd0;
      for (int k = 0; k < 10; k++) begin
         d = 64'sd0;
         if (bx[2*k+2]) d = d - 64'sd2;
         if (bx[2*k+1]) d = d + 64'sd1;
         if (bx[2*k])   d = d + 64'sd1;
         p = d * av;
         r[20*k +: 20] = p[19:0];
      end
      return r;
   endfunction

   function automatic logic [35:0] ref_mul(input logic [17:0] a, input logic [17:0] b,
                                          input logic sa, input logic sb);
      logic signed [63:0] av;
      logic signed [63:0] bv;
      logic signed [63:0] p;
      av = sa ? {{46{a[17]}}, a} : {46'd0, a};
      bv = sb ? {{46{b[17]}}, b} : {46'd0, b};
      p  = av * bv;
      return p[35:0];
   endfunction

   task automatic model(input logic [35:0] ep, input logic ps, input logic ld);
      logic [47:0] e;
      logic [47:0] s;
      e = ps ? {{12{ep[35]}}, ep} : {12'd0, ep};
      if (ld) begin
         m_acc = e;
         m_ovf = 1'b0;
      end else begin
         s = m_acc + e;
         if ((m_acc[47] == e[47]) && (s[47] != m_acc[47])) m_ovf = 1'b1;
         m_acc = s;
      end
   endtask

   task automatic send(input logic [17:0] a, input logic [17:0] b, input logic sa,
                       input logic sb, input logic ld, input logic [35:0] ep,
                       input logic [47:0] ea, input logic eo, input bit push);
      logic [199:0] r;
      acc_t         e;
      r = booth(a, b, sa, sb);
      for (int k = 0; k < 10; k++) pp[k] = r[20*k +: 20];
      multa_ns = sa;
      multb_ns = sb;
      acc_load = ld;
      valid    = 1'b1;
      if (push) begin
         e.acc = ea;
         e.ovf = eo;
         q_prod.push_back(ep);
         q_acc.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: compares on enabled edges only.
   always begin
      logic        ce_s;
      logic [35:0] ep;
      acc_t        ea;
      @(posedge clk);
      ce_s = ce;
      #1;
      if (sb_en && !rst && ce_s) begin
         if (o_p_valid) begin
            if (q_prod.size() == 0) chk("sb_unexpected_product", 64'd1, 64'd0);
            else begin
               ep = q_prod.pop_front();
               chk("sb_product", 64'(o_product), 64'(ep));
            end
         end
         if (o_acc_valid) begin
            run = run + 1;
            if (run > max_run) max_run = run;
            if (q_acc.size() == 0) chk("sb_unexpected_acc", 64'd1, 64'd0);
            else begin
               ea = q_acc.pop_front();
               chk("sb_acc", 64'(o_acc), 64'(ea.acc));
               chk("sb_acc_ovf", 64'(o_acc_ovf), 64'(ea.ovf));
            end
         end else begin
            run = 0;
         end
      end
   end

   initial begin
      logic [17:0] ra;
      logic [17:0] rb;
      logic [35:0] ep;
      n_chk = 0; n_pass = 0; run = 0; max_run = 0;
      m_acc = 48'd0; m_ovf = 1'b0; sb_en = 1'b1;
      tbl[0] = '{18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 36'h000000001, 48'h000000000001};
      tbl[1] = '{18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 36'hFFFF80001, 48'h000FFFF80001};
      tbl[2] = '{18'h20000, 18'h3FFFF, 1'b1, 1'b0, 36'h800020000, 48'hFFF800020000};
      tbl[3] = '{18'h00000, 18'h12345, 1'b1, 1'b1, 36'h000000000, 48'h000000000000};
      tbl[4] = '{18'h00003, 18'h00005, 1'b0, 1'b0, 36'h00000000F, 48'h00000000000F};
      tbl[5] = '{18'h3FFFF, 18'h00002, 1'b1, 1'b0, 36'hFFFFFFFFE, 48'hFFFFFFFFFFFE};
      tbl[6] = '{18'h1FFFF, 18'h1FFFF, 1'b1, 1'b1, 36'h3FFFC0001, 48'h0003FFFC0001};
      tbl[7] = '{18'h20000, 18'h20000, 1'b1, 1'b1, 36'h400000000, 48'h000400000000};

      rst = 1'b1; ce = 1'b1; valid = 1'b0; acc_clr = 1'b0; acc_load = 1'b0;
      multa_ns = 1'b0; multb_ns = 1'b0;
      for (int k = 0; k < 10; k++) pp[k] = 20'd0;
      repeat (3) @(negedge clk);
      chk("reset_product", 64'(o_product), 64'd0);
      chk("reset_p_valid", 64'(o_p_valid), 64'd0);
      chk("reset_acc", 64'(o_acc), 64'd0);
      chk("reset_acc_valid", 64'(o_acc_valid), 64'd0);
      chk("reset_acc_ovf", 64'(o_acc_ovf), 64'd0);
      rst = 1'b0;

      // table of corner products, each loaded into the accumulator
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, 1'b1, tbl[i].prod, tbl[i].acc, 1'b0, 1'b1);
         m_acc = tbl[i].acc;
         m_ovf = 1'b0;
      end
      idle(6);
      chk("drain_table", 64'(q_prod.size() + q_acc.size()), 64'd0);

      // 100 random signed pairs back-to-back
      max_run = 0;
      for (int i = 0; i < 100; i++) begin
         ra = 18'($urandom);
         rb = 18'($urandom);
         ep = ref_mul(ra, rb, 1'b1, 1'b1);
         model(ep, 1'b1, (i == 0));
         send(ra, rb, 1'b1, 1'b1, (i == 0), ep, m_acc, m_ovf, 1'b1);
      end
      idle(6);
      chk("drain_stream", 64'(q_prod.size() + q_acc.size()), 64'd0);
      chk("acc_valid_run", 64'(max_run), 64'd100);

      // overflow: 8192 * 2^34 = 2^47
      for (int i = 0; i < 8192; i++) begin
         ep = ref_mul(18'h20000, 18'h20000, 1'b1, 1'b1);
         model(ep, 1'b1, (i == 0));
         send(18'h20000, 18'h20000, 1'b1, 1'b1, (i == 0), ep, m_acc, m_ovf, 1'b1);
      end
      idle(6);
      chk("drain_ovf", 64'(q_prod.size() + q_acc.size()), 64'd0);
      chk("ovf_final_acc", 64'(o_acc), 64'h0000800000000000);
      chk("ovf_sticky_idle", 64'(o_acc_ovf), 64'd1);
      model(36'h00000000F, 1'b0, 1'b1);
      send(18'd3, 18'd5, 1'b0, 1'b0, 1'b1, 36'h00000000F, m_acc, m_ovf, 1'b1);
      idle(6);
      chk("ovf_cleared_by_load", 64'(o_acc_ovf), 64'd0);
      chk("acc_after_reload", 64'(o_acc), 64'hF);
      sb_en = 1'b0;

      // clear with no product in S3
      acc_clr = 1'b1;
      @(posedge clk); #1;
      chk("clr_idle_acc", 64'(o_acc), 64'd0);
      chk("clr_idle_acc_valid", 64'(o_acc_valid), 64'd0);
      @(negedge clk);
      acc_clr = 1'b0;

      // clear colliding with an accumulate of 5
      send(18'd7, 18'd1, 1'b0, 1'b0, 1'b1, 36'd0, 48'd0, 1'b0, 1'b0);
      idle(4);
      chk("collide_pre_acc", 64'(o_acc), 64'd7);
      send(18'd5, 18'd1, 1'b0, 1'b0, 1'b0, 36'd0, 48'd0, 1'b0, 1'b0);
      valid = 1'b0;
      @(negedge clk);
      acc_clr = 1'b1;
      @(posedge clk); #1;
      chk("collide_acc", 64'(o_acc), 64'd5);
      chk("collide_ovf", 64'(o_acc_ovf), 64'd0);
      chk("collide_acc_valid", 64'(o_acc_valid), 64'd1);
      @(negedge clk);
      acc_clr = 1'b0;
      idle(2);

      // stall: ce = 1,0,1,1 with a product of 12 added to 5
      {multa_ns, multb_ns} = 2'b00;
      send(18'd3, 18'd4, 1'b0, 1'b0, 1'b0, 36'd0, 48'd0, 1'b0, 1'b0);
      valid = 1'b0; ce = 1'b0; acc_clr = 1'b1;
      @(posedge clk); #1;
      chk("stall_p_valid_e1", 64'(o_p_valid), 64'd0);
      chk("stall_clr_ignored", 64'(o_acc), 64'd5);
      @(negedge clk);
      ce = 1'b1; acc_clr = 1'b0;
      @(posedge clk); #1;
      chk("stall_p_valid_e2", 64'(o_p_valid), 64'd1);
      chk("stall_product", 64'(o_product), 64'd12);
      @(posedge clk); #1;
      chk("stall_p_valid_e3", 64'(o_p_valid), 64'd0);
      chk("stall_acc", 64'(o_acc), 64'd17);
      chk("stall_acc_valid", 64'(o_acc_valid), 64'd1);
      @(negedge clk);

      // asynchronous reset with sets in flight
      send(18'd9, 18'd9, 1'b0, 1'b0, 1'b0, 36'd0, 48'd0, 1'b0, 1'b0);
      send(18'd8, 18'd8, 1'b0, 1'b0, 1'b0, 36'd0, 48'd0, 1'b0, 1'b0);
      send(18'd7, 18'd7, 1'b0, 1'b0, 1'b0, 36'd0, 48'd0, 1'b0, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("arst_product", 64'(o_product), 64'd0);
      chk("arst_p_valid", 64'(o_p_valid), 64'd0);
      chk("arst_acc", 64'(o_acc), 64'd0);
      chk("arst_acc_valid", 64'(o_acc_valid), 64'd0);
      chk("arst_acc_ovf", 64'(o_acc_ovf), 64'd0);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("arst_no_stale_valid", 64'({o_p_valid, o_acc_valid}), 64'd0);
      end
      @(negedge clk);
      send(18'd2, 18'd3, 1'b0, 1'b0, 1'b1, 36'd0, 48'd0, 1'b0, 1'b0);
      valid = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_p_valid", 64'(o_p_valid), 64'd1);
      chk("post_rst_product", 64'(o_product), 64'd6);
      @(posedge clk); #1;
      chk("post_rst_acc", 64'(o_acc), 64'd6);
      chk("post_rst_acc_valid", 64'(o_acc_valid), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
